// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state encoding, error counter width and saturating increment
package clk_mon_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} mon_state_e;
  localparam int ERR_W = 8;
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);
  logic meta;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) {q_o, meta} <= 2'b00;
    else {q_o, meta} <= {meta, d_i};
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a divided clock and tracks lock
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXPECTED_PERIOD = 125,
  parameter int TOLERANCE       = 1,
  parameter int LOCK_COUNT      = 4,
  parameter int COUNTER_WIDTH   = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     mon_i,
  output logic [COUNTER_WIDTH-1:0] period_o,
  output logic [COUNTER_WIDTH-1:0] high_o,
  output logic                     valid_o,
  output logic                     good_o,
  output logic                     lock_o,
  output logic                     stuck_o,
  output logic [ERR_W-1:0]         err_cnt_o
);
  localparam int CW = COUNTER_WIDTH;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] P_MIN   = CW'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CW-1:0] P_MAX   = CW'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [CW-1:0] H_MIN   = CW'((EXPECTED_PERIOD - 1) / 2 - TOLERANCE);
  localparam logic [CW-1:0] H_MAX   = CW'((EXPECTED_PERIOD + 1) / 2 + TOLERANCE);
  localparam logic [CW-1:0] TIMEOUT = CW'(2 * EXPECTED_PERIOD);

  logic          mon_s, mon_d, rise, fall, have_fall, meas_good;
  logic [CW-1:0] cnt, hi_cap;
  logic [GW-1:0] good_cnt;
  mon_state_e    state;

  sync_2ff u_sync (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(mon_i), .q_o(mon_s));

  assign rise = mon_s & ~mon_d;
  assign fall = ~mon_s & mon_d;
  assign meas_good = have_fall && cnt >= P_MIN && cnt <= P_MAX && hi_cap >= H_MIN && hi_cap <= H_MAX;

  // one extra delay flop for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) mon_d <= 1'b0;
    else mon_d <= mon_s;

  // cycles since the last rise; restarts at 1 so the closing rise reads the full period
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else if (rise) cnt <= CW'(1);
    else if (~&cnt) cnt <= cnt + 1'b1;

  // capture the high time at the first fall after a rise
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      have_fall <= 1'b0;
      hi_cap    <= '0;
    end else if (rise) begin
      have_fall <= 1'b0;
    end else if (fall && !have_fall) begin
      have_fall <= 1'b1;
      hi_cap    <= cnt;
    end

  // lock tracking FSM with registered outputs; a rise takes priority over the timeout
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state     <= IDLE;
      good_cnt  <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      good_o    <= 1'b0;
      lock_o    <= 1'b0;
      stuck_o   <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (rise) begin
        stuck_o <= 1'b0;
        if (state == IDLE) begin
          state    <= TRACK;
          good_cnt <= '0;
        end else begin
          valid_o  <= 1'b1;
          period_o <= cnt;
          high_o   <= have_fall ? hi_cap : '0;
          good_o   <= meas_good;
          if (!meas_good) begin
            state     <= TRACK;
            good_cnt  <= '0;
            lock_o    <= 1'b0;
            err_cnt_o <= sat_inc(err_cnt_o);
          end else if (state == TRACK && good_cnt == GW'(LOCK_COUNT - 1)) begin
            state  <= LOCKED;
            lock_o <= 1'b1;
          end else if (state == TRACK) begin
            good_cnt <= good_cnt + 1'b1;
          end
        end
      end else if (state != IDLE && cnt == TIMEOUT) begin
        state     <= IDLE;
        good_cnt  <= '0;
        lock_o    <= 1'b0;
        stuck_o   <= 1'b1;
        err_cnt_o <= sat_inc(err_cnt_o);
      end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;
  typedef struct {
    int per;
    int hlo;
    int hhi;
    int good;
    int lock;
    int err;
  } exp_t;

  logic       clk_i = 1'b0, rst_n_i = 1'b0, mon_drv = 1'b0, div_en = 1'b0, tp = 1'b0, tn = 1'b0;
  logic       mon_i, valid_o, good_o, lock_o, stuck_o;
  logic [8:0] period_o, high_o;
  logic [7:0] err_cnt_o;
  int         dcnt = 0;
  int         checks = 0, errors = 0;
  exp_t       q[$];
  int         m_gc = 0, m_err = 0, m_p = 0, m_h = 0;
  bit         m_lock = 0, m_prev = 0;
  bit         chk_next = 0, next_lock = 0;

  assign mon_i = div_en ? (tp ^ tn) : mon_drv;

  clk_div_monitor dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .mon_i(mon_i), .period_o(period_o), .high_o(high_o),
    .valid_o(valid_o), .good_o(good_o), .lock_o(lock_o), .stuck_o(stuck_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ideal odd /125 divider: posedge and negedge toggles XORed
  always @(posedge clk_i)
    if (div_en) begin
      if (dcnt == 0) tp <= ~tp;
      dcnt <= (dcnt == 124) ? 0 : dcnt + 1;
    end
  always @(negedge clk_i)
    if (div_en && dcnt == 63) tn <= ~tn;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return v >= 255 ? 255 : v + 1;
  endfunction

  task automatic m_reset();
    m_gc = 0; m_err = 0; m_lock = 0; m_prev = 0;
  endtask

  task automatic rise_model();
    bit g;
    if (m_prev) begin
      g = (m_p >= 124 && m_p <= 126 && m_h >= 61 && m_h <= 64);
      if (g) begin
        m_gc++;
        if (m_gc >= 4) m_lock = 1;
      end else begin
        m_gc = 0;
        m_lock = 0;
        m_err = sat(m_err);
      end
      q.push_back('{m_p, m_h, m_h, int'(g), int'(m_lock), m_err});
    end
    m_prev = 1;
  endtask

  // called at a negedge; drives one exact period and returns at a negedge
  task automatic period(input int p, input int h);
    rise_model();
    m_p = p;
    m_h = h;
    mon_drv = 1'b1;
    repeat (h) @(negedge clk_i);
    mon_drv = 1'b0;
    repeat (p - h) @(negedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk_i);
    check("drain", q.size(), 0);
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, "_period"}, period_o, 0);
    check({tag, "_high"}, high_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_good"}, good_o, 0);
    check({tag, "_lock"}, lock_o, 0);
    check({tag, "_stuck"}, stuck_o, 0);
    check({tag, "_err"}, err_cnt_o, 0);
  endtask

  // monitor: pop and compare on every valid_o, then recheck lock one cycle later
  always @(negedge clk_i) begin : mon_blk
    exp_t e;
    if (chk_next) begin
      check("lock_after_valid", lock_o, next_lock);
      chk_next = 0;
    end
    if (rst_n_i && valid_o) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("period", period_o, e.per);
        checks++;
        if (high_o < 9'(e.hlo) || high_o > 9'(e.hhi)) begin
          errors++;
          $display("FAIL high actual %0d required %0d..%0d", high_o, e.hlo, e.hhi);
        end
        check("good", good_o, e.good);
        check("lock", lock_o, e.lock);
        check("err_cnt", err_cnt_o, e.err);
        chk_next = 1;
        next_lock = e.lock[0];
      end
    end
  end

  initial begin
    #12 zero_outputs("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 6; i++) q.push_back('{125, 62, 63, 1, int'(i >= 3), 0});
    div_en = 1'b1;
    drain();
    repeat (30) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    div_en = 1'b0;
    mon_drv = 1'b0;
    #1 zero_outputs("async_rst");
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    m_reset();
    repeat (3) @(negedge clk_i);
    repeat (6) period(125, 62);
    period(124, 62);
    period(126, 63);
    period(123, 61);
    period(127, 63);
    repeat (6) period(125, 62);
    repeat (127) @(negedge clk_i);
    check("stuck_pre", stuck_o, 0);
    check("lock_pre", lock_o, 1);
    @(negedge clk_i);
    m_prev = 0; m_gc = 0; m_lock = 0; m_err = sat(m_err);
    check("stuck_set", stuck_o, 1);
    check("lock_timeout", lock_o, 0);
    check("err_timeout", err_cnt_o, m_err);
    repeat (132) @(negedge clk_i);
    period(125, 62);
    check("stuck_clear", stuck_o, 0);
    repeat (5) period(125, 62);
    period(125, 70);
    period(125, 70);
    period(125, 62);
    check("track_after_bad_high", lock_o, 0);
    repeat (300) period(60, 30);
    period(125, 62);
    drain();
    check("err_saturated", err_cnt_o, 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
